// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the inter-stage pipeline registers.
// Imported by the pipeline stage register and its sub-modules.
package pipe_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INS          = 32'h0;
    localparam logic [4:0]  GPR_ZERO         = 5'd0;
    localparam int          TNEW_W_DEFAULT   = 2;

    typedef logic [TNEW_W_DEFAULT-1:0] tnew_t;

    // Saturating decrement, widened so any TNEW_W can use it.
    function automatic logic [31:0] tnew_dec(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : t - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register: flush > stall > advance, with valid,
// saturating Tnew countdown and stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W     = 64,
    parameter int          TNEW_W        = TNEW_W_DEFAULT,
    parameter logic [31:0] PC_RESET      = PC_RESET_DEFAULT,
    parameter bit          FLUSH_KEEP_PC = 1'b1,
    parameter int          CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [31:0]          in_ins,
    input  logic [31:0]          in_pc,
    input  logic [4:0]           in_rd,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    output logic [31:0]          out_ins,
    output logic [31:0]          out_pc,
    output logic [4:0]           out_rd,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_wen,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    logic                 valid_q;
    logic [31:0]          ins_q;
    logic [31:0]          pc_q;
    logic [4:0]           rd_q;
    logic [TNEW_W-1:0]    tnew_q;
    logic [PAYLOAD_W-1:0] data_q;
    logic                 wen_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INS;
            pc_q    <= PC_RESET;
            rd_q    <= GPR_ZERO;
            tnew_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ins_q   <= NOP_INS;
            pc_q    <= FLUSH_KEEP_PC ? in_pc : PC_RESET;
            rd_q    <= GPR_ZERO;
            tnew_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            ins_q   <= in_ins;
            pc_q    <= in_pc;
            rd_q    <= in_rd;
            tnew_q  <= TNEW_W'(tnew_dec(32'(in_tnew)));
            data_q  <= in_data;
            wen_q   <= in_valid && (in_rd != GPR_ZERO);
        end
    end

    assign out_valid = valid_q;
    assign out_ins   = ins_q;
    assign out_pc    = pc_q;
    assign out_rd    = rd_q;
    assign out_tnew  = tnew_q;
    assign out_data  = data_q;
    assign out_wen   = wen_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (stall),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: default instance plus one with
// FLUSH_KEEP_PC=0 and 3-bit counters.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        stall, flush, in_valid;
    logic [31:0] in_ins, in_pc;
    logic [4:0]  in_rd;
    logic [1:0]  in_tnew;
    logic [63:0] in_data;

    logic        a_valid, a_wen;
    logic [31:0] a_ins, a_pc;
    logic [4:0]  a_rd;
    logic [1:0]  a_tnew;
    logic [63:0] a_data;
    logic [15:0] a_scnt, a_fcnt;

    logic        b_valid, b_wen;
    logic [31:0] b_ins, b_pc;
    logic [4:0]  b_rd;
    logic [1:0]  b_tnew;
    logic [63:0] b_data;
    logic [2:0]  b_scnt, b_fcnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pcb;
        logic [4:0]  rd;
        logic [1:0]  tn;
        logic [63:0] d;
        logic        wen;
        logic [15:0] sc, fc;
        logic [2:0]  scb, fcb;
    } exp_t;

    exp_t m;
    exp_t q[$];

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .clr_n(clr_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
        .in_rd(in_rd), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(a_valid), .out_ins(a_ins), .out_pc(a_pc),
        .out_rd(a_rd), .out_tnew(a_tnew), .out_data(a_data),
        .out_wen(a_wen), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipe_stage_reg #(.FLUSH_KEEP_PC(1'b0), .CNT_W(3)) u_b (
        .clk(clk), .clr_n(clr_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .in_pc(in_pc),
        .in_rd(in_rd), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(b_valid), .out_ins(b_ins), .out_pc(b_pc),
        .out_rd(b_rd), .out_tnew(b_tnew), .out_data(b_data),
        .out_wen(b_wen), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m.v = 0; m.ins = 0; m.pc = 32'h3000; m.pcb = 32'h3000;
        m.rd = 0; m.tn = 0; m.d = 0; m.wen = 0;
        m.sc = 0; m.fc = 0; m.scb = 0; m.fcb = 0;
    endtask

    task automatic compare_all(input exp_t e);
        check("a_valid", 64'(a_valid), 64'(e.v));
        check("a_ins",   64'(a_ins),   64'(e.ins));
        check("a_pc",    64'(a_pc),    64'(e.pc));
        check("a_rd",    64'(a_rd),    64'(e.rd));
        check("a_tnew",  64'(a_tnew),  64'(e.tn));
        check("a_data",  a_data,       e.d);
        check("a_wen",   64'(a_wen),   64'(e.wen));
        check("a_scnt",  64'(a_scnt),  64'(e.sc));
        check("a_fcnt",  64'(a_fcnt),  64'(e.fc));
        check("b_valid", 64'(b_valid), 64'(e.v));
        check("b_ins",   64'(b_ins),   64'(e.ins));
        check("b_pc",    64'(b_pc),    64'(e.pcb));
        check("b_rd",    64'(b_rd),    64'(e.rd));
        check("b_tnew",  64'(b_tnew),  64'(e.tn));
        check("b_data",  b_data,       e.d);
        check("b_wen",   64'(b_wen),   64'(e.wen));
        check("b_scnt",  64'(b_scnt),  64'(e.scb));
        check("b_fcnt",  64'(b_fcnt),  64'(e.fcb));
    endtask

    // Drive one cycle of stimulus, predict, clock, then score.
    task automatic step(input logic s, input logic f, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [1:0] tn,
                        input logic [63:0] d);
        exp_t e;
        stall = s; flush = f; in_valid = v; in_ins = ins;
        in_pc = pc; in_rd = rd; in_tnew = tn; in_data = d;
        if (f) begin
            m.v = 0; m.ins = 0; m.rd = 0; m.tn = 0; m.d = 0; m.wen = 0;
            m.pc = pc; m.pcb = 32'h3000;
        end else if (!s) begin
            m.v = v; m.ins = ins; m.pc = pc; m.pcb = pc; m.rd = rd;
            m.tn = (tn == 2'd0) ? 2'd0 : tn - 2'd1;
            m.d = d; m.wen = v && (rd != 5'd0);
        end
        if (s && m.sc != 16'hffff) m.sc++;
        if (f && m.fc != 16'hffff) m.fc++;
        if (s && m.scb != 3'd7) m.scb++;
        if (f && m.fcb != 3'd7) m.fcb++;
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            compare_all(e);
        end
    endtask

    initial begin
        clr_n = 0; stall = 0; flush = 0; in_valid = 0;
        in_ins = 0; in_pc = 0; in_rd = 0; in_tnew = 0; in_data = 0;
        model_reset();
        #12;
        compare_all(m);
        clr_n = 1;
        #1;

        step(0, 0, 1, 32'h0000_1111, 32'h3004, 5'd3, 2'd2, 64'hA5);
        check("tnew_dec_2", 64'(a_tnew), 64'd1);
        step(0, 0, 1, 32'h0000_2222, 32'h3008, 5'd5, 2'd0, 64'hB6);
        check("tnew_sat_0", 64'(a_tnew), 64'd0);
        check("wen_rd5", 64'(a_wen), 64'd1);

        step(0, 0, 1, 32'h0000_3333, 32'h300c, 5'd9, 2'd2, 64'hC7);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 32'hdead_0000 + 32'(i), 32'h4000 + 32'(i),
                 5'd31, 2'd3, 64'(i) + 64'h55);
        check("stall_hold_tnew", 64'(a_tnew), 64'd1);
        check("stall_cnt_3", 64'(a_scnt), 64'd3);

        step(1, 1, 1, 32'h0000_4444, 32'h3010, 5'd4, 2'd2, 64'hD8);
        check("flush_keep_pc", 64'(a_pc), 64'h3010);
        check("flush_reset_pc", 64'(b_pc), 64'h3000);
        check("flush_cnt_1", 64'(a_fcnt), 64'd1);

        step(0, 0, 1, 32'h0000_5555, 32'h3014, 5'd0, 2'd1, 64'hE9);
        check("wen_rd0", 64'(a_wen), 64'd0);
        step(0, 0, 0, 32'h0000_6666, 32'h3018, 5'd7, 2'd3, 64'hFA);
        check("bubble_rd7", 64'(a_rd), 64'd7);
        check("bubble_wen", 64'(a_wen), 64'd0);

        for (int i = 0; i < 10; i++)
            step(1, 0, 1, 32'(i), 32'h5000, 5'd2, 2'd2, 64'(i));
        check("sat_cnt_7", 64'(b_scnt), 64'd7);

        // Async reset mid-stall and mid-flush, checked between edges.
        stall = 1; flush = 1;
        #2;
        clr_n = 0;
        #1;
        model_reset();
        compare_all(m);
        @(posedge clk);
        #1;
        compare_all(m);
        clr_n = 1;
        stall = 0; flush = 0;

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom;
            step(r[0] & r[1], r[2] & r[3], r[4], $urandom, $urandom,
                 5'(r[9:5]), 2'(r[11:10]), {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
